shift_unit_ctrl: RTL and testbench



---
 rtl/shift_unit_ctrl.sv | 159 +++++++++++++++
 tb/tb_shift_unit_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_unit_ctrl
// Purpose  : Two-port round-robin front end for a shared 8-bit barrel shifter;
//            rotate-left is built from two shifter passes.
// Revision : 1.0 - initial release
// ============================================================================
module shift_unit_ctrl #(
    parameter bit ROT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       r0_valid,
    output logic       r0_ready,
    input  logic [7:0] r0_din,
    input  logic [2:0] r0_shamt,
    input  logic [1:0] r0_op,
    input  logic       r1_valid,
    output logic       r1_ready,
    input  logic [7:0] r1_din,
    input  logic [2:0] r1_shamt,
    input  logic [1:0] r1_op,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_id,
    output logic       busy,
    output logic [7:0] sh_din,
    output logic [2:0] sh_shamt,
    output logic       sh_lr,
    output logic       sh_al,
    input  logic [7:0] sh_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS1 = 2'd1,
        S_PASS2 = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] c_OP_SRL = 2'b01;
    localparam logic [1:0] c_OP_SRA = 2'b10;
    localparam logic [1:0] c_OP_ROL = 2'b11;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_rr_ptr;
    logic [7:0] r_din;
    logic [2:0] r_shamt;
    logic [1:0] r_op;
    logic       r_id;
    logic [7:0] r_acc;
    logic       r_res_valid;
    logic [7:0] r_res_data;
    logic       r_res_id;

    logic       w_any_valid;
    logic       w_gnt_id;
    logic       w_two_pass;

    assign w_any_valid = r0_valid | r1_valid;
    // Contention resolves to the pointer; otherwise whichever side is asking.
    assign w_gnt_id    = (r0_valid & r1_valid) ? r_rr_ptr : r1_valid;
    // A zero-distance rotate is just the first pass, so PASS2 is skipped.
    assign w_two_pass  = ROT_EN && (r_op == c_OP_ROL) && (r_shamt != 3'd0);

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign busy      = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        r0_ready    = 1'b0;
        r1_ready    = 1'b0;
        sh_din      = 8'd0;
        sh_shamt    = 3'd0;
        sh_lr       = 1'b0;
        sh_al       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_valid) begin
                    r0_ready    = ~w_gnt_id;
                    r1_ready    = w_gnt_id;
                    w_state_nxt = S_PASS1;
                end
            end
            S_PASS1: begin
                sh_din      = r_din;
                sh_shamt    = r_shamt;
                sh_lr       = (r_op != c_OP_SRL) && (r_op != c_OP_SRA);
                sh_al       = (r_op == c_OP_SRA);
                w_state_nxt = w_two_pass ? S_PASS2 : S_DONE;
            end
            S_PASS2: begin
                // Right shift by (8 - n) mod 8 supplies the wrapped-around bits.
                sh_din      = r_din;
                sh_shamt    = 3'd0 - r_shamt;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= 1'b0;
            r_din       <= 8'd0;
            r_shamt     <= 3'd0;
            r_op        <= 2'd0;
            r_id        <= 1'b0;
            r_acc       <= 8'd0;
            r_res_valid <= 1'b0;
            r_res_data  <= 8'd0;
            r_res_id    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_any_valid) begin
                        r_din    <= w_gnt_id ? r1_din   : r0_din;
                        r_shamt  <= w_gnt_id ? r1_shamt : r0_shamt;
                        r_op     <= w_gnt_id ? r1_op    : r0_op;
                        r_id     <= w_gnt_id;
                        r_rr_ptr <= ~w_gnt_id;
                    end
                end
                S_PASS1: begin
                    r_acc <= sh_dout;
                    if (!w_two_pass) begin
                        r_res_data  <= sh_dout;
                        r_res_id    <= r_id;
                        r_res_valid <= 1'b1;
                    end
                end
                S_PASS2: begin
                    r_res_data  <= r_acc | sh_dout;
                    r_res_id    <= r_id;
                    r_res_valid <= 1'b1;
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_unit_ctrl
// Purpose  : Directed self-checking bench for shift_unit_ctrl with a
//            behavioural barrel shifter attached to the sh_* port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_unit_ctrl;

    logic       clk;
    logic       rst;
    logic       r0_valid, r0_ready, r1_valid, r1_ready;
    logic [7:0] r0_din, r1_din;
    logic [2:0] r0_shamt, r1_shamt;
    logic [1:0] r0_op, r1_op;
    logic       res_valid, res_ready, res_id, busy;
    logic [7:0] res_data;
    logic [7:0] sh_din, sh_dout;
    logic [2:0] sh_shamt;
    logic       sh_lr, sh_al;

    logic       n_r0_valid, n_r0_ready, n_r1_ready;
    logic [7:0] n_r0_din;
    logic [2:0] n_r0_shamt;
    logic [1:0] n_r0_op;
    logic       n_res_valid, n_res_id, n_busy;
    logic [7:0] n_res_data, n_sh_din, n_sh_dout;
    logic [2:0] n_sh_shamt;
    logic       n_sh_lr, n_sh_al;

    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] shifter(input logic [7:0] d, input logic [2:0] n,
                                           input logic lr, input logic al);
        if (lr)      return d << n;
        else if (al) return 8'($signed(d) >>> n);
        else         return d >> n;
    endfunction

    assign sh_dout   = shifter(sh_din, sh_shamt, sh_lr, sh_al);
    assign n_sh_dout = shifter(n_sh_din, n_sh_shamt, n_sh_lr, n_sh_al);

    shift_unit_ctrl #(.ROT_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_din(r0_din),
        .r0_shamt(r0_shamt), .r0_op(r0_op),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_din(r1_din),
        .r1_shamt(r1_shamt), .r1_op(r1_op),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .busy(busy),
        .sh_din(sh_din), .sh_shamt(sh_shamt), .sh_lr(sh_lr), .sh_al(sh_al),
        .sh_dout(sh_dout)
    );

    shift_unit_ctrl #(.ROT_EN(1'b0)) u_dut_nr (
        .clk(clk), .rst(rst),
        .r0_valid(n_r0_valid), .r0_ready(n_r0_ready), .r0_din(n_r0_din),
        .r0_shamt(n_r0_shamt), .r0_op(n_r0_op),
        .r1_valid(1'b0), .r1_ready(n_r1_ready), .r1_din(8'd0),
        .r1_shamt(3'd0), .r1_op(2'd0),
        .res_valid(n_res_valid), .res_ready(1'b1), .res_data(n_res_data),
        .res_id(n_res_id), .busy(n_busy),
        .sh_din(n_sh_din), .sh_shamt(n_sh_shamt), .sh_lr(n_sh_lr), .sh_al(n_sh_al),
        .sh_dout(n_sh_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " res_valid"}, res_valid, 8'd0);
        check({tag, " busy"},      busy,      8'd0);
        check({tag, " sh_din"},    sh_din,    8'd0);
        check({tag, " sh_shamt"},  sh_shamt,  8'd0);
        check({tag, " sh_lr"},     sh_lr,     8'd0);
        check({tag, " sh_al"},     sh_al,     8'd0);
    endtask

    initial begin
        rst = 1'b1; res_ready = 1'b1;
        r0_valid = 0; r0_din = 0; r0_shamt = 0; r0_op = 0;
        r1_valid = 0; r1_din = 0; r1_shamt = 0; r1_op = 0;
        n_r0_valid = 0; n_r0_din = 0; n_r0_shamt = 0; n_r0_op = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check_idle_outputs("reset");
        check("reset res_data", res_data, 8'h00);
        check("reset res_id", res_id, 8'd0);
        check("reset r0_ready", r0_ready, 8'd0);

        // r0 SRA 0x96 >>> 3
        r0_valid = 1; r0_din = 8'h96; r0_shamt = 3'd3; r0_op = 2'b10;
        #1;
        check("sra r0_ready", r0_ready, 8'd1);
        check("sra r1_ready", r1_ready, 8'd0);
        tick();
        r0_valid = 0;
        check("sra p1 busy", busy, 8'd1);
        check("sra p1 sh_din", sh_din, 8'h96);
        check("sra p1 sh_shamt", sh_shamt, 8'd3);
        check("sra p1 sh_lr", sh_lr, 8'd0);
        check("sra p1 sh_al", sh_al, 8'd1);
        check("sra p1 res_valid", res_valid, 8'd0);
        tick();
        check("sra res_valid", res_valid, 8'd1);
        check("sra res_data", res_data, 8'hF2);
        check("sra res_id", res_id, 8'd0);
        check("sra done sh_din", sh_din, 8'd0);
        tick();
        check("sra back idle valid", res_valid, 8'd0);
        check("sra back idle busy", busy, 8'd0);

        // r1 ROL 0x81 by 1 (pointer now favours r1; r1 alone anyway)
        r1_valid = 1; r1_din = 8'h81; r1_shamt = 3'd1; r1_op = 2'b11;
        #1;
        check("rol r1_ready", r1_ready, 8'd1);
        tick();
        r1_valid = 0;
        check("rol p1 sh_shamt", sh_shamt, 8'd1);
        check("rol p1 sh_lr", sh_lr, 8'd1);
        tick();
        check("rol p2 sh_shamt", sh_shamt, 8'd7);
        check("rol p2 sh_lr", sh_lr, 8'd0);
        check("rol p2 sh_din", sh_din, 8'h81);
        check("rol p2 res_valid", res_valid, 8'd0);
        tick();
        check("rol res_valid", res_valid, 8'd1);
        check("rol res_data", res_data, 8'h03);
        check("rol res_id", res_id, 8'd1);
        tick();

        // ROL by 0 finishes after one pass
        r0_valid = 1; r0_din = 8'hA5; r0_shamt = 3'd0; r0_op = 2'b11;
        tick();
        r0_valid = 0;
        check("rol0 p1 sh_shamt", sh_shamt, 8'd0);
        tick();
        check("rol0 res_valid", res_valid, 8'd1);
        check("rol0 res_data", res_data, 8'hA5);
        tick();

        // Alternation with both requesters continuously valid from reset
        rst = 1'b1; tick(); rst = 1'b0;
        r0_valid = 1; r0_din = 8'h81; r0_shamt = 3'd1; r0_op = 2'b00;
        r1_valid = 1; r1_din = 8'h80; r1_shamt = 3'd7; r1_op = 2'b01;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("alt r0_ready", r0_ready, (k % 2 == 0) ? 8'd1 : 8'd0);
            check("alt r1_ready", r1_ready, (k % 2 == 1) ? 8'd1 : 8'd0);
            tick();
            tick();
            check("alt res_valid", res_valid, 8'd1);
            check("alt res_data", res_data, (k % 2 == 0) ? 8'h02 : 8'h01);
            check("alt res_id", res_id, 8'(k % 2));
            tick();
        end

        // Backpressure: pointer is back at r0
        res_ready = 0;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp res_valid", res_valid, 8'd1);
            check("bp res_data", res_data, 8'h02);
            check("bp res_id", res_id, 8'd0);
            check("bp r0_ready", r0_ready, 8'd0);
            check("bp r1_ready", r1_ready, 8'd0);
            check("bp busy", busy, 8'd1);
            tick();
        end
        res_ready = 1; r0_valid = 0; r1_valid = 0;
        tick();
        check("bp release valid", res_valid, 8'd0);
        check("bp release busy", busy, 8'd0);

        // Reset during PASS2 of a rotate from r1
        r1_valid = 1; r1_din = 8'h81; r1_shamt = 3'd1; r1_op = 2'b11;
        #1;
        check("rst-rol r1_ready", r1_ready, 8'd1);
        tick();
        r1_valid = 0;
        tick();
        check("rst-rol in pass2", sh_shamt, 8'd7);
        rst = 1;
        tick();
        rst = 0;
        check_idle_outputs("mid-reset");
        check("mid-reset res_data", res_data, 8'h00);
        tick();
        check("mid-reset no response", res_valid, 8'd0);
        r0_valid = 1; r0_din = 8'h01; r0_shamt = 3'd7; r0_op = 2'b00;
        r1_valid = 1; r1_din = 8'h10; r1_shamt = 3'd1; r1_op = 2'b01;
        #1;
        check("post-reset r0_ready", r0_ready, 8'd1);
        check("post-reset r1_ready", r1_ready, 8'd0);
        tick();
        r0_valid = 0; r1_valid = 0;
        tick();
        check("post-reset res_valid", res_valid, 8'd1);
        check("post-reset res_data", res_data, 8'h80);
        check("post-reset res_id", res_id, 8'd0);
        tick();

        // ROT_EN=0 build: op 11 behaves as SLL
        n_r0_valid = 1; n_r0_din = 8'h81; n_r0_shamt = 3'd1; n_r0_op = 2'b11;
        #1;
        check("nr r0_ready", n_r0_ready, 8'd1);
        tick();
        n_r0_valid = 0;
        check("nr p1 sh_lr", n_sh_lr, 8'd1);
        check("nr p1 sh_shamt", n_sh_shamt, 8'd1);
        tick();
        check("nr res_valid", n_res_valid, 8'd1);
        check("nr res_data", n_res_data, 8'h02);
        check("nr res_id", n_res_id, 8'd0);
        tick();
        check("nr back idle", n_busy, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
